// File: rtl/op_branch_unit_if.sv
// Branch request channel between decode/execute and the branch unit.
// The requester drives the master side and the branch unit sits on the slave side.
interface op_branch_unit_if #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 24
) ();
    logic              br_valid;
    logic              br_ready;
    logic [1:0]        br_type;
    logic              cond_pass;
    logic [OFF_W-1:0]  br_off;
    logic [DATA_W-1:0] reg_val;
    logic              src_is_lr;
    logic [DATA_W-1:0] pc_in;

    modport master (
        output br_valid, br_type, cond_pass, br_off, reg_val, src_is_lr, pc_in,
        input  br_ready
    );

    modport slave (
        input  br_valid, br_type, cond_pass, br_off, reg_val, src_is_lr, pc_in,
        output br_ready
    );
endinterface

// File: rtl/op_branch_unit.sv
// Branch resolution unit: B/BL/BX/BLX target, link write, INVSTATE fault and timed flush.
// Optional return-address stack is enabled by defining OP_BRANCH_RAS_EN.
module op_branch_unit #(
    parameter int DATA_W       = 32,
    parameter int OFF_W        = 24,
    parameter int PC_INC       = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    op_branch_unit_if.slave   br,
    output logic [DATA_W-1:0] pc_out,
    output logic              pc_load,
    output logic [DATA_W-1:0] lr_out,
    output logic              lr_we,
    output logic              flush,
    output logic              fault,
    output logic              busy,
    output logic              ras_hit
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [3:0]        CNT_INIT = 4'(FLUSH_CYCLES);
    localparam logic [DATA_W-1:0] LSB_CLR  = {{(DATA_W-1){1'b1}}, 1'b0};
    localparam logic [DATA_W-1:0] LSB_SET  = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_nx;
    logic [3:0]        cnt_r, cnt_nx;
    logic [1:0]        type_r;
    logic              cond_r, lr_src_r;
    logic [OFF_W-1:0]  off_r;
    logic [DATA_W-1:0] val_r, pc_r;

    logic [DATA_W-1:0] pc_out_r, pc_out_nx, lr_out_r, lr_out_nx;
    logic              pc_load_r, pc_load_nx, lr_we_r, lr_we_nx;
    logic              flush_r, flush_nx, fault_r, fault_nx, ras_hit_r, ras_hit_nx;

    logic              accept_s, is_reg_s, is_link_s, bad_state_s, ras_match_s;
    logic [DATA_W-1:0] off_ext_s, target_s, ret_addr_s;

    assign br.br_ready = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign pc_out      = pc_out_r;
    assign pc_load     = pc_load_r;
    assign lr_out      = lr_out_r;
    assign lr_we       = lr_we_r;
    assign flush       = flush_r;
    assign fault       = fault_r;
    assign ras_hit     = ras_hit_r;

    // Target, return address and Thumb-state check from the latched request.
    always_comb begin
        is_reg_s    = type_r[1];
        is_link_s   = type_r[0];
        off_ext_s   = DATA_W'($signed(off_r));
        bad_state_s = is_reg_s && !val_r[0];
        ret_addr_s  = (pc_r + DATA_W'(PC_INC)) | LSB_SET;
        if (is_reg_s) begin
            target_s = val_r & LSB_CLR;
        end else begin
            target_s = pc_r + (off_ext_s << 1);
        end
    end

    // Next-state and next-output logic of the IDLE/RESOLVE/FLUSH controller.
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        accept_s   = 1'b0;
        flush_nx   = 1'b0;
        pc_load_nx = 1'b0;
        lr_we_nx   = 1'b0;
        fault_nx   = 1'b0;
        ras_hit_nx = 1'b0;
        pc_out_nx  = pc_out_r;
        lr_out_nx  = lr_out_r;
        case (state_r)
            ST_IDLE: begin
                if (br.br_valid) begin
                    accept_s = 1'b1;
                    state_nx = ST_RESOLVE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RESOLVE: begin
                if (cond_r) begin
                    state_nx = ST_FLUSH;
                    cnt_nx   = CNT_INIT;
                    flush_nx = 1'b1;
                    if (bad_state_s) begin
                        fault_nx = 1'b1;
                    end else begin
                        pc_load_nx = 1'b1;
                        pc_out_nx  = target_s;
                        ras_hit_nx = is_reg_s && lr_src_r && ras_match_s;
                    end
                    if (is_link_s) begin
                        lr_we_nx  = 1'b1;
                        lr_out_nx = ret_addr_s;
                    end else begin
                        lr_we_nx = 1'b0;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // flush drops one cycle before IDLE so the next accept follows the drop.
                if (cnt_r == 4'd0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx   = cnt_r - 4'd1;
                    flush_nx = (cnt_r > 4'd1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            type_r    <= 2'd0;
            cond_r    <= 1'b0;
            lr_src_r  <= 1'b0;
            off_r     <= '0;
            val_r     <= '0;
            pc_r      <= '0;
            pc_out_r  <= '0;
            lr_out_r  <= '0;
            pc_load_r <= 1'b0;
            lr_we_r   <= 1'b0;
            flush_r   <= 1'b0;
            fault_r   <= 1'b0;
            ras_hit_r <= 1'b0;
        end else begin
            state_r   <= state_nx;
            cnt_r     <= cnt_nx;
            pc_out_r  <= pc_out_nx;
            lr_out_r  <= lr_out_nx;
            pc_load_r <= pc_load_nx;
            lr_we_r   <= lr_we_nx;
            flush_r   <= flush_nx;
            fault_r   <= fault_nx;
            ras_hit_r <= ras_hit_nx;
            if (accept_s) begin
                type_r   <= br.br_type;
                cond_r   <= br.cond_pass;
                lr_src_r <= br.src_is_lr;
                off_r    <= br.br_off;
                val_r    <= br.reg_val;
                pc_r     <= br.pc_in;
            end
        end
    end

`ifdef OP_BRANCH_RAS_EN
    localparam int              PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]  RAS_FULL = (PTR_W+1)'(RAS_DEPTH);
    localparam logic [PTR_W:0]  RAS_NONE = (PTR_W+1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DATA_W-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr_r, ras_ptr_nx, top_idx_s, ptr_pop_s;
    logic [PTR_W:0]    ras_cnt_r, ras_cnt_nx, cnt_pop_s;
    logic              pop_s, push_s, pop_ok_s;

    // Stack bookkeeping: ras_ptr_r is the next write slot; pop is applied before push.
    always_comb begin
        top_idx_s   = ras_ptr_r - PTR_ONE;
        pop_s       = (state_r == ST_RESOLVE) && cond_r && is_reg_s && !bad_state_s && lr_src_r;
        push_s      = (state_r == ST_RESOLVE) && cond_r && is_link_s;
        pop_ok_s    = pop_s && (ras_cnt_r != RAS_NONE);
        ras_match_s = (ras_cnt_r != RAS_NONE) && ((ras_mem_r[top_idx_s] & LSB_CLR) == target_s);
        if (pop_ok_s) begin
            ptr_pop_s = top_idx_s;
            cnt_pop_s = ras_cnt_r - (PTR_W+1)'(1);
        end else begin
            ptr_pop_s = ras_ptr_r;
            cnt_pop_s = ras_cnt_r;
        end
        if (push_s) begin
            ras_ptr_nx = ptr_pop_s + PTR_ONE;
            ras_cnt_nx = (cnt_pop_s == RAS_FULL) ? cnt_pop_s : cnt_pop_s + (PTR_W+1)'(1);
        end else begin
            ras_ptr_nx = ptr_pop_s;
            ras_cnt_nx = cnt_pop_s;
        end
    end

    // Pointer and occupancy registers; reset empties the stack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_ptr_r <= '0;
            ras_cnt_r <= '0;
        end else begin
            ras_ptr_r <= ras_ptr_nx;
            ras_cnt_r <= ras_cnt_nx;
        end
    end

    // Stack storage; entries beyond the count are never read.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            ras_mem_r[ptr_pop_s] <= ret_addr_s;
        end
    end
`else
    assign ras_match_s = 1'b0;
`endif

endmodule

// File: tb/tb_op_branch_unit.sv
// Self-checking bench for op_branch_unit: directed vector table, multi-cycle corner
// sequences and randomized branches checked against a behavioural model.
module tb_op_branch_unit;
    localparam int FC = 2;
    localparam int RD = 4;

    typedef struct {
        logic [1:0]  t;
        logic        c;
        logic [23:0] off;
        logic [31:0] val;
        logic [31:0] pc;
        logic        lr_src;
    } req_t;

    typedef struct {
        logic        pc_load;
        logic        lr_we;
        logic        fault;
        logic        ras_hit;
        logic        flush;
        logic [31:0] pc_out;
        logic [31:0] lr_out;
    } exp_t;

    typedef struct {
        req_t r;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] pc_out, lr_out;
    logic pc_load, lr_we, flush, fault, busy, ras_hit;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc, m_lr;
    logic [31:0] ras_q[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    op_branch_unit_if #(.DATA_W(32), .OFF_W(24)) bif ();

    op_branch_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .br      (bif),
        .pc_out  (pc_out),
        .pc_load (pc_load),
        .lr_out  (lr_out),
        .lr_we   (lr_we),
        .flush   (flush),
        .fault   (fault),
        .busy    (busy),
        .ras_hit (ras_hit)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: what the architecture says a branch does, one request at a time.
    function automatic exp_t model(input req_t r);
        exp_t e;
        logic [31:0] tgt;
        logic thumb;
        e = '{pc_load: 1'b0, lr_we: 1'b0, fault: 1'b0, ras_hit: 1'b0, flush: 1'b0,
              pc_out: m_pc, lr_out: m_lr};
        if (r.c) begin
            e.flush = 1'b1;
            if (r.t >= 2'd2) begin
                tgt   = r.val & ~32'h1;
                thumb = r.val[0];
            end else begin
                tgt   = 32'(longint'(r.pc) + 64'sd2 * longint'($signed(r.off)));
                thumb = 1'b1;
            end
            if (thumb) begin
                e.pc_load = 1'b1;
                e.pc_out  = tgt;
                m_pc      = tgt;
`ifdef OP_BRANCH_RAS_EN
                if (r.t >= 2'd2 && r.lr_src && ras_q.size() > 0) begin
                    logic [31:0] top;
                    top       = ras_q.pop_back();
                    e.ras_hit = ((top & ~32'h1) == tgt);
                end
`endif
            end else begin
                e.fault = 1'b1;
            end
            if (r.t == 2'd1 || r.t == 2'd3) begin
                e.lr_we  = 1'b1;
                e.lr_out = (r.pc + 32'd1) | 32'd1;
                m_lr     = e.lr_out;
`ifdef OP_BRANCH_RAS_EN
                ras_q.push_back(e.lr_out);
                if (ras_q.size() > RD) void'(ras_q.pop_front());
`endif
            end
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] t, input logic c, input logic [23:0] off,
                                input logic [31:0] val, input logic [31:0] pc,
                                input logic pl, input logic lw, input logic f, input logic fl,
                                input logic [31:0] pco, input logic [31:0] lro);
        vec_t v;
        v.r = '{t: t, c: c, off: off, val: val, pc: pc, lr_src: 1'b0};
        v.e = '{pc_load: pl, lr_we: lw, fault: f, ras_hit: 1'b0, flush: fl, pc_out: pco, lr_out: lro};
        return v;
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        m_lr = 32'd0;
        ras_q.delete();
    endtask

    task automatic drive(input req_t r);
        bif.br_type   = r.t;
        bif.cond_pass = r.c;
        bif.br_off    = r.off;
        bif.reg_val   = r.val;
        bif.pc_in     = r.pc;
        bif.src_is_lr = r.lr_src;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (br_ready_now() !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".ready_wait"}, 32'(bif.br_ready), 32'd1);
    endtask

    function automatic logic br_ready_now();
        return bif.br_ready;
    endfunction

    // One complete request: accept, resolve, strobe cycle, flush window, back to ready.
    task automatic do_branch(input req_t r, input exp_t e, input string tag);
        wait_ready(tag);
        drive(r);
        bif.br_valid = 1'b1;
        @(negedge clk);
        bif.br_valid  = 1'b0;
        bif.br_type   = 2'($urandom);
        bif.cond_pass = 1'($urandom);
        bif.br_off    = 24'($urandom);
        bif.reg_val   = $urandom;
        bif.pc_in     = $urandom;
        chk({tag, ".resolve_busy"}, 32'(busy), 32'd1);
        chk({tag, ".resolve_ready"}, 32'(bif.br_ready), 32'd0);
        chk({tag, ".resolve_pc_load"}, 32'(pc_load), 32'd0);
        @(negedge clk);
        chk({tag, ".pc_load"}, 32'(pc_load), 32'(e.pc_load));
        chk({tag, ".lr_we"}, 32'(lr_we), 32'(e.lr_we));
        chk({tag, ".fault"}, 32'(fault), 32'(e.fault));
        chk({tag, ".ras_hit"}, 32'(ras_hit), 32'(e.ras_hit));
        chk({tag, ".pc_out"}, pc_out, e.pc_out);
        chk({tag, ".lr_out"}, lr_out, e.lr_out);
        chk({tag, ".flush"}, 32'(flush), 32'(e.flush));
        if (e.flush) begin
            for (int k = 1; k < FC; k++) begin
                @(negedge clk);
                chk({tag, ".flush_hold"}, 32'(flush), 32'd1);
                chk({tag, ".strobe_once"}, {29'd0, pc_load, lr_we, fault}, 32'd0);
            end
            @(negedge clk);
            chk({tag, ".flush_drop"}, 32'(flush), 32'd0);
            chk({tag, ".tail_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            chk({tag, ".ready_back"}, 32'(bif.br_ready), 32'd1);
        end else begin
            chk({tag, ".ready_back"}, 32'(bif.br_ready), 32'd1);
            chk({tag, ".idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_t r;
        exp_t e;

        bif.br_valid = 1'b0;
        drive('{t: 2'd0, c: 1'b0, off: 24'd0, val: 32'd0, pc: 32'd0, lr_src: 1'b0});
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.pc_out", pc_out, 32'd0);
        chk("reset.lr_out", lr_out, 32'd0);
        chk("reset.strobes", {26'd0, pc_load, lr_we, flush, fault, ras_hit, 1'b0}, 32'd0);
        rst_n = 1'b1;
        chk("reset.ready", 32'(bif.br_ready), 32'd1);
        chk("reset.busy", 32'(busy), 32'd0);
        model_reset();

        tbl[0]  = mk(2'd0, 1'b1, 24'h000010, 32'h0,      32'h100,      1, 0, 0, 1, 32'h120,      32'h0);
        tbl[1]  = mk(2'd1, 1'b1, 24'hFFFFF8, 32'h0,      32'h200,      1, 1, 0, 1, 32'h1F0,      32'h201);
        tbl[2]  = mk(2'd2, 1'b0, 24'h0,      32'h401,    32'h240,      0, 0, 0, 0, 32'h1F0,      32'h201);
        tbl[3]  = mk(2'd3, 1'b1, 24'h0,      32'h400,    32'h300,      0, 1, 1, 1, 32'h1F0,      32'h301);
        tbl[4]  = mk(2'd2, 1'b1, 24'h0,      32'h401,    32'h310,      1, 0, 0, 1, 32'h400,      32'h301);
        tbl[5]  = mk(2'd0, 1'b1, 24'h000010, 32'h0,      32'hFFFFFFF0, 1, 0, 0, 1, 32'h10,       32'h301);
        tbl[6]  = mk(2'd1, 1'b0, 24'h000020, 32'h0,      32'h50,       0, 0, 0, 0, 32'h10,       32'h301);
        tbl[7]  = mk(2'd1, 1'b1, 24'h7FFFFF, 32'h0,      32'h1000,     1, 1, 0, 1, 32'h1000FFE,  32'h1001);
        tbl[8]  = mk(2'd1, 1'b1, 24'h800000, 32'h0,      32'h2000000,  1, 1, 0, 1, 32'h1000000,  32'h2000001);
        tbl[9]  = mk(2'd3, 1'b1, 24'h0,      32'h8001,   32'h3000,     1, 1, 0, 1, 32'h8000,     32'h3001);
        tbl[10] = mk(2'd2, 1'b1, 24'h0,      32'h12,     32'h20,       0, 0, 1, 1, 32'h8000,     32'h3001);
        tbl[11] = mk(2'd1, 1'b1, 24'h0,      32'h0,      32'h7,        1, 1, 0, 1, 32'h7,        32'h9);

        foreach (tbl[i]) begin
            void'(model(tbl[i].r));
            do_branch(tbl[i].r, tbl[i].e, $sformatf("vec%0d", i));
        end

        // br_valid held high across a branch: second request only taken after the flush tail.
        wait_ready("hold");
        r = '{t: 2'd0, c: 1'b1, off: 24'h4, val: 32'h0, pc: 32'h500, lr_src: 1'b0};
        void'(model(r));
        drive(r);
        bif.br_valid = 1'b1;
        @(negedge clk);
        r = '{t: 2'd1, c: 1'b1, off: 24'h8, val: 32'h0, pc: 32'h600, lr_src: 1'b0};
        drive(r);
        chk("hold.busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("hold.first_load", 32'(pc_load), 32'd1);
        chk("hold.first_pc", pc_out, 32'h508);
        repeat (FC) begin
            @(negedge clk);
            chk("hold.no_accept", {30'd0, pc_load, bif.br_ready}, 32'd0);
        end
        @(negedge clk);
        chk("hold.ready", 32'(bif.br_ready), 32'd1);
        @(negedge clk);
        bif.br_valid = 1'b0;
        chk("hold.second_busy", 32'(busy), 32'd1);
        @(negedge clk);
        e = model(r);
        chk("hold.second_load", 32'(pc_load), 32'(e.pc_load));
        chk("hold.second_pc", pc_out, e.pc_out);
        chk("hold.second_lr", lr_out, e.lr_out);
        chk("hold.second_lr_we", 32'(lr_we), 32'(e.lr_we));

        // Reset during the second flush cycle discards the branch in flight.
        wait_ready("rst");
        r = '{t: 2'd1, c: 1'b1, off: 24'h10, val: 32'h0, pc: 32'h700, lr_src: 1'b0};
        drive(r);
        bif.br_valid = 1'b1;
        @(negedge clk);
        bif.br_valid = 1'b0;
        @(negedge clk);
        chk("rst.strobe", 32'(pc_load), 32'd1);
        chk("rst.pc", pc_out, 32'h720);
        @(negedge clk);
        chk("rst.flush2", 32'(flush), 32'd1);
        rst_n = 1'b0;
        r = '{t: 2'd0, c: 1'b1, off: 24'h2, val: 32'h0, pc: 32'h800, lr_src: 1'b0};
        drive(r);
        bif.br_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("rst.flush", 32'(flush), 32'd0);
        chk("rst.pc_out", pc_out, 32'd0);
        chk("rst.lr_out", lr_out, 32'd0);
        chk("rst.ready", 32'(bif.br_ready), 32'd1);
        @(negedge clk);
        bif.br_valid = 1'b0;
        chk("rst.reaccept_busy", 32'(busy), 32'd1);
        @(negedge clk);
        e = model(r);
        chk("rst.reaccept_load", 32'(pc_load), 32'(e.pc_load));
        chk("rst.reaccept_pc", pc_out, e.pc_out);
        chk("rst.reaccept_lr", lr_out, e.lr_out);

`ifdef OP_BRANCH_RAS_EN
        // Return-address stack: five calls into a four-deep stack, then five returns.
        wait_ready("ras");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 5; i++) begin
            r = '{t: 2'd1, c: 1'b1, off: 24'h0, val: 32'h0, pc: 32'(i * 16), lr_src: 1'b0};
            e = model(r);
            do_branch(r, e, $sformatf("ras_call%0d", i));
        end
        for (int i = 0; i < 5; i++) begin
            r = '{t: 2'd2, c: 1'b1, off: 24'h0, val: 32'h51 - 32'(i * 16), pc: 32'h900, lr_src: 1'b1};
            e = model(r);
            e.ras_hit = (i < 4);
            do_branch(r, e, $sformatf("ras_ret%0d", i));
        end
`endif

        // Randomized branches against the model.
        for (int i = 0; i < 40; i++) begin
            r.t      = 2'($urandom_range(0, 3));
            r.c      = ($urandom_range(0, 3) != 0);
            r.off    = 24'($urandom);
            r.val    = $urandom;
            r.pc     = $urandom;
            r.lr_src = 1'($urandom_range(0, 1));
            e = model(r);
            do_branch(r, e, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/op_branch_unit.md
Name: op_branch_unit

Overview:
- Parametrised branch resolution unit for the Cortex-M0 core; successor to the register-branch operator.
- Handles four branch kinds (B imm, BL imm, BX reg, BLX reg) with condition gating, target computation, link-register write and EXEC-state (Thumb bit) checking.
- Drives a timed pipeline flush after every taken branch.
- Sits between decode/execute and the PC/register-file write ports; a valid/ready handshake accepts one branch at a time.

Parameters:
- DATA_W, 32, width of PC, register operand, target and LR.
- OFF_W, 24, width of the signed immediate branch offset, in halfword units.
- PC_INC, 1, increment added to pc_in to form the return address.
- FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch; legal range 1..15.
- RAS_DEPTH, 4, return-address-stack entries; power of two, 2..16; used only with the optional feature.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- br_valid  in  1  branch request valid.
- br_ready  out  1  unit can accept a request.
- br_type  in  2  0=B, 1=BL, 2=BX, 3=BLX.
- cond_pass  in  1  condition-code check result; sampled with the request.
- br_off  in  OFF_W  signed halfword offset for B/BL.
- reg_val  in  DATA_W  source register value for BX/BLX.
- src_is_lr  in  1  BX/BLX source register is LR; used only by the optional feature.
- pc_in  in  DATA_W  PC of the branch instruction.
- pc_out  out  DATA_W  resolved branch target.
- pc_load  out  1  one-cycle strobe: PC takes pc_out.
- lr_out  out  DATA_W  return address.
- lr_we  out  1  one-cycle strobe: LR takes lr_out.
- flush  out  1  pipeline flush.
- fault  out  1  one-cycle strobe: BX/BLX to a target with bit0=0 (INVSTATE).
- busy  out  1  unit not in IDLE.
- ras_hit  out  1  one-cycle strobe: popped stack entry matched the target; tied 0 without the optional feature.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - pc_out=0, lr_out=0; pc_load, lr_we, flush, fault, ras_hit all 0.
  - br_ready=1 and busy=0 once reset is released.
  - Reset takes effect at any point, including mid-flush; everything in flight is discarded.
- States: IDLE, RESOLVE, FLUSH.
- IDLE:
  - br_ready=1.
  - On br_valid&&br_ready, latch br_type, cond_pass, br_off, reg_val, pc_in and src_is_lr, then go to RESOLVE.
  - Request fields need to be valid only in the accept cycle.
- RESOLVE (exactly one cycle, br_ready=0, busy=1):
  - cond_pass=0: no strobes; go to IDLE. The branch is not taken and there is no flush.
  - B/BL target = pc_in + (sign_extend(br_off) << 1), computed modulo 2^DATA_W; wrap-around is silently allowed.
  - BX/BLX with reg_val[0]=1: target = reg_val with bit0 cleared.
  - BX/BLX with reg_val[0]=0: pulse fault for 1 cycle; no pc_load, no lr_we; go to FLUSH.
  - Taken, no fault: register pc_out; pulse pc_load for 1 cycle; go to FLUSH.
  - BL/BLX taken, including the faulting case: lr_out = pc_in + PC_INC with bit0 forced to 1; pulse lr_we in the same cycle as pc_load or fault.
  - B/BX: lr_out holds its previous value and lr_we stays 0.
- Strobe timing: strobes are registered outputs and are high in the cycle after RESOLVE, which is the first FLUSH cycle. Accept-to-strobe latency is 2 cycles.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles, counted by an internal down-counter; then go to IDLE.
  - br_valid is ignored while not in IDLE.
- Back-to-back requests: the earliest next accept is in the cycle after flush drops.
- pc_out and lr_out hold their last values between branches.

Optional Feature:
- Macro: OP_BRANCH_RAS_EN.
- Defined:
  - Adds a RAS_DEPTH-entry circular return-address stack with a pointer and an occupancy count.
  - Every taken BL/BLX (lr_we=1) pushes lr_out. When full, the push overwrites the oldest entry and the count saturates at RAS_DEPTH.
  - Every taken, non-faulting BX/BLX with src_is_lr=1 pops one entry.
  - ras_hit pulses with pc_load when the popped entry (bit0 cleared) equals pc_out.
  - Pop when empty: ras_hit=0, pointer and count unchanged.
  - A BLX that pops and pushes in the same branch does the pop first, then the push.
  - Reset empties the stack.
- Undefined: no stack storage; ras_hit is constant 0; src_is_lr is unused.

Test Plan:
- B taken: reset, then pc_in=0x100, br_off=0x000010, cond_pass=1 -> 2 cycles after accept pc_load=1 and pc_out=0x120; flush high for 2 cycles; lr_we=0.
- BL backward: pc_in=0x200, br_off=0xFFFFF8 -> pc_out=0x1F0; lr_we=1 with lr_out=0x201; br_ready returns to 1 3 cycles after the strobe.
- BX condition failed: reg_val=0x401, cond_pass=0 -> no pc_load, no flush, no fault; br_ready=1 again 2 cycles after accept.
- BLX to 0x400 (bit0=0) -> fault=1 for 1 cycle, pc_load=0, lr_we=1; flush still asserted for FLUSH_CYCLES.
- Reset mid-flush: rst_n=0 during the second flush cycle -> next cycle flush=0, pc_out=0, br_ready=1; a br_valid held during busy is not accepted until IDLE.
- With OP_BRANCH_RAS_EN, RAS_DEPTH=4: five BLs from pc_in=0x10..0x50, then BX LR to 0x51 -> ras_hit=1. Further BX LR pops hit 0x41, 0x31, 0x21 in turn; the fifth pop on an empty stack gives ras_hit=0.
